// File: rtl/lfsr_stream.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_stream
//  Description : Fibonacci LFSR pseudo-random word source with a valid/ready
//                output stream. STEPS single-bit shifts are unrolled
//                combinationally and applied on each accepted transfer.
//                Detects the return to the loaded seed and reports the
//                measured period in advances.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH  register width (2..32)
//    TAPS   feedback mask; bit i set => state[i] feeds the XOR; MSB must be 1
//    STEPS  single-bit shifts per advance (1..WIDTH)
//    CNT_W  width of the period counter
//  Ports
//    clk         in   rising-edge clock
//    reset       in   synchronous, active-high
//    load_seed   in   load seed_data (all-ones substituted for zero)
//    seed_data   in   seed value
//    stop        in   return to IDLE, state retained
//    out_data    out  current LFSR state
//    out_valid   out  out_data is valid (RUN state)
//    out_ready   in   consumer accepts out_data
//    lfsr_done   out  one-cycle pulse: state returned to the seed
//    period_len  out  advances per period, latched at lfsr_done
//    seed_fixed  out  one-cycle pulse: an all-zero seed was replaced
// ============================================================================
module lfsr_stream #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
  parameter int               STEPS = 1,
  parameter int               CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_seed,
  input  logic [WIDTH-1:0] seed_data,
  input  logic             stop,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lfsr_done,
  output logic [CNT_W-1:0] period_len,
  output logic             seed_fixed
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_stream: WIDTH must be in 2..32");
    end
    if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
      $error("lfsr_stream: TAPS[WIDTH-1] must be set");
    end
    if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
      $error("lfsr_stream: STEPS must be in 1..WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       fsm_state;
  logic [0:0]       fsm_next;
  logic [WIDTH-1:0] lfsr_state;
  logic [WIDTH-1:0] seed_reg;
  logic [CNT_W-1:0] step_count;
  logic [WIDTH-1:0] adv_state;
  logic [WIDTH-1:0] load_value;
  logic             seed_zero;
  logic             advance;
  logic             seed_match;
  logic             count_sat;

  // --------------------------------------------------------------------------
  // Unrolled shift chain: chain[i+1] is chain[i] shifted once
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] chain [0:STEPS];

  assign chain[0] = lfsr_state;

  generate
    for (genvar i = 0; i < STEPS; i++) begin : g_step
      assign chain[i+1] = {chain[i][WIDTH-2:0], ^(chain[i] & TAPS)};
    end
  endgenerate

  assign adv_state = chain[STEPS];

  // --------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_state <= ST_IDLE;
    end else begin
      fsm_state <= fsm_next;
    end
  end

  // load_seed outranks stop, in either state.
  always_comb begin
    fsm_next = fsm_state;
    if (load_seed) begin
      fsm_next = ST_RUN;
    end else if (stop) begin
      fsm_next = ST_IDLE;
    end
  end

  always_comb begin
    out_valid = (fsm_state == ST_RUN);
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  // An all-zero seed would lock the register, so substitute all-ones.
  assign seed_zero  = (seed_data == '0);
  assign load_value = seed_zero ? ALL_ONES : seed_data;

  // A handshake coinciding with load_seed or stop is discarded.
  assign advance    = out_valid && out_ready && !load_seed && !stop;
  assign seed_match = (adv_state == seed_reg);
  assign count_sat  = (step_count == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_state <= '0;
      seed_reg   <= '0;
      step_count <= '0;
      period_len <= '0;
      lfsr_done  <= 1'b0;
      seed_fixed <= 1'b0;
    end else begin
      lfsr_done  <= 1'b0;
      seed_fixed <= 1'b0;
      if (load_seed) begin
        lfsr_state <= load_value;
        seed_reg   <= load_value;
        step_count <= '0;
        seed_fixed <= seed_zero;
      end else if (advance) begin
        lfsr_state <= adv_state;
        if (seed_match) begin
          lfsr_done <= 1'b1;
          // A saturated count no longer measures the period; keep the old one.
          if (!count_sat) begin
            period_len <= step_count + CNT_ONE;
          end
          step_count <= '0;
        end else if (!count_sat) begin
          step_count <= step_count + CNT_ONE;
        end
      end
    end
  end

  assign out_data = lfsr_state;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_stream
//  Description : Self-checking bench for lfsr_stream. Three instances share
//                the stimulus: STEPS=1, STEPS=2, and STEPS=1 with a 3-bit
//                period counter (saturates before the 15-advance period).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lfsr_stream;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset     = 1'b1;
  logic       load_seed = 1'b0;
  logic       stop      = 1'b0;
  logic       out_ready = 1'b0;
  logic [3:0] seed_data = 4'h0;

  logic [3:0]  od [3];
  logic        ov [3];
  logic        dn [3];
  logic        sf [3];
  logic [31:0] pl0, pl1;
  logic [2:0]  pl2;

  lfsr_stream #(.WIDTH(4), .TAPS(4'b1100), .STEPS(1), .CNT_W(32)) dut0 (
    .clk(clk), .reset(reset), .load_seed(load_seed), .seed_data(seed_data),
    .stop(stop), .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready),
    .lfsr_done(dn[0]), .period_len(pl0), .seed_fixed(sf[0]));

  lfsr_stream #(.WIDTH(4), .TAPS(4'b1100), .STEPS(2), .CNT_W(32)) dut1 (
    .clk(clk), .reset(reset), .load_seed(load_seed), .seed_data(seed_data),
    .stop(stop), .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready),
    .lfsr_done(dn[1]), .period_len(pl1), .seed_fixed(sf[1]));

  lfsr_stream #(.WIDTH(4), .TAPS(4'b1100), .STEPS(1), .CNT_W(3)) dut2 (
    .clk(clk), .reset(reset), .load_seed(load_seed), .seed_data(seed_data),
    .stop(stop), .out_data(od[2]), .out_valid(ov[2]), .out_ready(out_ready),
    .lfsr_done(dn[2]), .period_len(pl2), .seed_fixed(sf[2]));

  int tests = 0;
  int fails = 0;

  // Single-step sequence from seed 1111 for x^4+x^3+1.
  logic [3:0] seq1 [15] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                            4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};

  // Reference model state
  int     m_steps [3] = '{1, 2, 1};
  longint m_cmax  [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd7};
  int     m_state [3];
  int     m_seed  [3];
  longint m_cnt   [3];
  longint m_per   [3];
  bit     m_done  [3];
  bit     m_run   = 1'b0;
  bit     m_fixed = 1'b0;
  bit     m_adv   = 1'b0;

  // n shifts: new value is 2*s mod 16 plus parity of bits 3 and 2.
  function automatic int ref_adv(int s, int n);
    int v = s;
    for (int j = 0; j < n; j++) begin
      v = ((v * 2) % 16) + ($countones(v[3:0] & 4'b1100) % 2);
    end
    return v;
  endfunction

  function automatic logic [31:0] get_pl(int k);
    if (k == 0) return pl0;
    if (k == 1) return pl1;
    return {29'd0, pl2};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: advance the model with the inputs sampled on this edge,
  // then compare every output of every instance just after the edge.
  task automatic tick();
    int ns;
    int sv;
    @(posedge clk);
    m_adv = !reset && !load_seed && !stop && m_run && out_ready;
    for (int k = 0; k < 3; k++) begin
      m_done[k] = 1'b0;
      if (reset) begin
        m_state[k] = 0; m_seed[k] = 0; m_cnt[k] = 0; m_per[k] = 0;
      end else if (load_seed) begin
        sv = (seed_data == 4'h0) ? 15 : int'(seed_data);
        m_state[k] = sv; m_seed[k] = sv; m_cnt[k] = 0;
      end else if (m_adv) begin
        ns = ref_adv(m_state[k], m_steps[k]);
        if (ns == m_seed[k]) begin
          m_done[k] = 1'b1;
          if (m_cnt[k] != m_cmax[k]) m_per[k] = m_cnt[k] + 1;
          m_cnt[k] = 0;
        end else if (m_cnt[k] != m_cmax[k]) begin
          m_cnt[k] = m_cnt[k] + 1;
        end
        m_state[k] = ns;
      end
    end
    m_fixed = !reset && load_seed && (seed_data == 4'h0);
    if (reset) m_run = 1'b0;
    else if (load_seed) m_run = 1'b1;
    else if (stop) m_run = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("out_data[%0d]", k),   {28'd0, od[k]}, m_state[k]);
      chk($sformatf("out_valid[%0d]", k),  {31'd0, ov[k]}, {31'd0, m_run});
      chk($sformatf("lfsr_done[%0d]", k),  {31'd0, dn[k]}, {31'd0, m_done[k]});
      chk($sformatf("period_len[%0d]", k), get_pl(k), m_per[k][31:0]);
      chk($sformatf("seed_fixed[%0d]", k), {31'd0, sf[k]}, {31'd0, m_fixed});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         acc;
    int         cyc;
    logic [3:0] held;

    // ---- reset state --------------------------------------------------------
    reset = 1'b1; out_ready = 1'b1;
    tick(); tick();
    chk("reset_out_data", {28'd0, od[0]}, 32'd0);
    chk("reset_valid", {31'd0, ov[0]}, 32'd0);
    reset = 1'b0;

    // ---- seed 1111, ready held high, STEPS=1 and STEPS=2 ------------------------
    seed_data = 4'hF; load_seed = 1'b1;
    tick();
    load_seed = 1'b0;
    chk("seq_load", {28'd0, od[0]}, {28'd0, seq1[0]});
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("seq1_word", {28'd0, od[0]}, {28'd0, seq1[i % 15]});
      chk("seq2_word", {28'd0, od[1]}, {28'd0, seq1[(2 * i) % 15]});
      chk("seq1_done", {31'd0, dn[0]}, (i == 15) ? 32'd1 : 32'd0);
    end
    chk("seq1_period", pl0, 32'd15);
    chk("seq2_period", pl1, 32'd15);
    chk("sat_done", {31'd0, dn[2]}, 32'd1);
    chk("sat_period", {29'd0, pl2}, 32'd0);

    // ---- random backpressure -----------------------------------------------
    seed_data = 4'hF; load_seed = 1'b1;
    tick();
    load_seed = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 15 && cyc < 300) begin
      out_ready = $urandom_range(0, 1) == 1;
      tick();
      cyc++;
      if (m_adv) acc++;
      chk("bp_word", {28'd0, od[0]}, {28'd0, seq1[acc % 15]});
    end
    chk("bp_accepted", acc, 32'd15);
    chk("bp_done", {31'd0, dn[0]}, 32'd1);
    chk("bp_period", pl0, 32'd15);

    // ---- zero seed substitution ----------------------------------------------
    out_ready = 1'b1; seed_data = 4'h0; load_seed = 1'b1;
    tick();
    load_seed = 1'b0;
    chk("zero_fixed", {31'd0, sf[0]}, 32'd1);
    chk("zero_state", {28'd0, od[0]}, 32'hF);
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 1) chk("zero_fixed_clear", {31'd0, sf[0]}, 32'd0);
      chk("zero_word", {28'd0, od[0]}, {28'd0, seq1[i % 15]});
    end
    chk("zero_done", {31'd0, dn[0]}, 32'd1);

    // ---- reload mid-run with a simultaneous handshake -------------------------
    tick(); tick(); tick();
    seed_data = 4'b0110; load_seed = 1'b1; out_ready = 1'b1;
    tick();
    load_seed = 1'b0;
    chk("reload_word0", {28'd0, od[0]}, 32'h6);
    chk("reload_word1", {28'd0, od[1]}, 32'h6);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("reload_done", {31'd0, dn[0]}, (i == 15) ? 32'd1 : 32'd0);
    end
    chk("reload_period", pl0, 32'd15);

    // ---- stop, then reset ----------------------------------------------------
    tick(); tick(); tick();
    held = od[0];
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_valid", {31'd0, ov[0]}, 32'd0);
    chk("stop_held", {28'd0, od[0]}, {28'd0, held});
    tick(); tick();
    chk("stop_ignores_ready", {28'd0, od[0]}, {28'd0, held});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_out_data", {28'd0, od[0]}, 32'd0);
    chk("rst_period", pl0, 32'd0);
    tick(); tick();
    chk("rst_idle_data", {28'd0, od[0]}, 32'd0);
    chk("rst_idle_valid", {31'd0, ov[0]}, 32'd0);

    // ---- randomized mixed traffic ------------------------------------------
    for (int i = 0; i < 400; i++) begin
      reset     = $urandom_range(0, 79) == 0;
      load_seed = $urandom_range(0, 11) == 0;
      seed_data = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      stop      = $urandom_range(0, 24) == 0;
      out_ready = $urandom_range(0, 2) != 0;
      tick();
    end
    reset = 1'b0; load_seed = 1'b0; stop = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lfsr_stream.md
# lfsr_stream

Parametrised LFSR pseudo-random generator: WIDTH-bit Fibonacci register with programmable taps, STEPS shifts per output word, and a valid/ready output stream. Advances only on an accepted transfer. Detects return to the loaded seed and reports the measured period. Used as a stimulus/scrambler source feeding downstream stream consumers.

## Interface
- WIDTH, 4, register width, 2..32
- TAPS, 4'b1100, feedback mask, WIDTH bits; bit i set means state[i] is XORed into feedback; TAPS[WIDTH-1] must be 1 (elaboration error otherwise); default is x^4+x^3+1 and every other WIDTH must override it
- STEPS, 1, single-bit shifts per advance, 1..WIDTH, unrolled combinationally
- CNT_W, 32, width of the period counter
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- load_seed  in  1  load seed_data on this edge
- seed_data  in  WIDTH  seed value
- stop  in  1  return to IDLE; state is retained
- out_data  out  WIDTH  current LFSR state
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts out_data
- lfsr_done  out  1  one-cycle pulse: state has returned to the seed
- period_len  out  CNT_W  advances per period, latched at each lfsr_done
- seed_fixed  out  1  one-cycle pulse: an all-zero seed was replaced

## Operation
- Single shift: fb = XOR(state & TAPS); next = {state[WIDTH-2:0], fb}.
- Advance means STEPS single shifts applied in one cycle.
- FSM has two states.
  - IDLE: out_valid=0. Entered on reset or stop.
  - RUN: out_valid=1. Entered on load_seed.
- Per-edge priority: reset > load_seed > stop > advance.
- load_seed (either state):
  - state <= seed_data and the seed register <= seed_data.
  - If seed_data==0, both load all-ones instead and seed_fixed pulses. This prevents lock-up.
  - step_count <= 0 and FSM <= RUN.
  - A simultaneous handshake is discarded and does not advance.
- stop: FSM <= IDLE; state, seed and counters are held. A later load_seed is the only way back to RUN.
- Advance condition: RUN && out_valid && out_ready && !load_seed && !stop.
  - If the advanced value == seed: lfsr_done <= 1, period_len <= step_count+1, step_count <= 0.
  - Otherwise: step_count <= step_count+1.
  - step_count saturates at all-ones. While saturated, period_len is not updated but lfsr_done still pulses.
- The first seed match occurs after P/gcd(STEPS,P) advances, where P is the single-step sequence period.
- out_ready is ignored in IDLE. out_data is always driven with the current state.

## Timing
- Reset values: out_data=0, out_valid=0, lfsr_done=0, period_len=0, seed_fixed=0, FSM=IDLE, step_count=0.
- load_seed sampled at edge N: out_data=seed and out_valid=1 from N+1.
- Handshake at edge N: the new out_data is visible from N+1. There is no bubble, so back-to-back advances run every cycle while out_ready=1.
- out_ready low: out_data and out_valid are held stable, as stream protocol requires.
- lfsr_done and period_len update on the same edge as the state that equals the seed. lfsr_done lasts exactly one cycle unless the next advance also matches. That only happens when the effective period is 1.
- seed_fixed pulses in cycle N+1 only.
- stop at edge N: out_valid=0 from N+1.
- Reset mid-RUN: all outputs return to their reset values on the next edge. out_data=0 until the next load.

## Test plan
- Reset then load 4'b1111, out_ready=1 → out_data follows 1111,1110,1100,1000,0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111, then 1111. lfsr_done pulses with period_len=15.
- Same stimulus with STEPS=2 → 1111,1100,0001,0100,0011,1101,0101,0111,1110,… Back at 1111 after 15 advances, period_len=15.
- Toggle out_ready randomly (about 50%) → out_data only changes on cycles after valid&&ready. The sequence is identical to the first test, and lfsr_done fires after exactly 15 accepted words.
- Load seed_data=0 → seed_fixed pulses once and out_data=1111 the next cycle. The sequence and period match the first test.
- In RUN, assert load_seed=1 (seed 4'b0110) together with out_ready=1 → next out_data=0110 with no advance. step_count restarts and lfsr_done fires 15 advances later.
- Mid-sequence stop then reset → after stop: out_valid=0 with the state held. After reset: all outputs 0 and out_ready is ignored until load_seed.
